hi_reader_corr: RTL



---
 rtl/hi_reader_corr.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/hi_reader_corr.sv
// hi_reader_corr
//   I/Q subcarrier correlator and SSP serialiser for the HF reader path.
//   Correlates ADC samples against square-wave I/Q references over a window of
//   2^WIN_LOG2 samples. At each window boundary the result is formatted
//   (saturated I/Q pair or amplitude estimate) and shifted out MSB first on the
//   SSP link. All logic runs on the falling edge of ck_1356meg.
//
// Ports
//   ck_1356meg  in   13.56 MHz sample clock (falling-edge active)
//   rst_n       in   asynchronous active-low reset
//   adc_d       in   unsigned ADC sample
//   sc_sel      in   subcarrier select (0=1695k, 1=848k, 2=424k, 3=212k)
//   mode        in   0=IQ, 1=amplitude, 2=IQ+sniff, 3=amplitude+sniff
//   clr_sat     in   clears sat_flag (a coincident saturation event wins)
//   ssp_clk     out  serial clock at ck/4
//   ssp_frame   out  frame marker
//   ssp_din     out  serial data, MSB first
//   corr_valid  out  one-cycle pulse when a window result is latched
//   sat_flag    out  sticky saturation indicator
//   debug       out  counter bit driving the I reference
module hi_reader_corr #(
  parameter int unsigned ADC_W    = 8,
  parameter int unsigned WIN_LOG2 = 6,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned SHIFT    = 4,
  parameter int unsigned HYST_TMO = 4095
) (
  input  logic             ck_1356meg,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_d,
  input  logic [1:0]       sc_sel,
  input  logic [1:0]       mode,
  input  logic             clr_sat,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             corr_valid,
  output logic             sat_flag,
  output logic             debug
);

  localparam int unsigned ACC_W = ADC_W + WIN_LOG2 + 1;
  localparam int unsigned SR_W  = 2 * OUT_W;
  localparam int unsigned EW    = (ACC_W > SR_W) ? ACC_W : SR_W;
  localparam int unsigned HC_W  = $clog2(HYST_TMO + 1);

  localparam logic [WIN_LOG2-1:0]    CNT_ONE   = WIN_LOG2'(1);
  localparam logic [WIN_LOG2-1:0]    CNT_THREE = WIN_LOG2'(3);
  localparam logic [WIN_LOG2-1:0]    CNT_HALF  = {1'b1, {(WIN_LOG2-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] IQ_MAX   = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] IQ_MIN   = ~IQ_MAX;
  localparam logic [EW-1:0]          AMP_MAX   = EW'({SR_W{1'b1}});
  localparam logic [HC_W-1:0]        HC_LAST   = HC_W'(HYST_TMO - 1);

  // state
  logic [WIN_LOG2-1:0]     cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
  logic [SR_W-1:0]         sr_q, sr_d;
  logic [1:0]              mode_sh_q, mode_sh_d;
  logic [1:0]              sc_sh_q, sc_sh_d;
  logic                    det_q, det_d;
  logic [HC_W-1:0]         hcnt_q, hcnt_d;
  logic                    h0_q, h0_d;
  logic                    h1_q, h1_d;
  logic                    sat_q, sat_d;
  logic                    clk_q, clk_d;
  logic                    frame_q, frame_d;
  logic                    valid_q, valid_d;

  // combinational helpers
  logic [2:0]              b_idx;
  logic [WIN_LOG2-1:0]     cnt_sh_b, cnt_sh_b1;
  logic                    ref_i, ref_q;
  logic signed [ACC_W-1:0] adc_ext;
  logic [OUT_W:0]          iq_i, iq_q;
  logic [ACC_W-1:0]        mag_i, mag_q, mag_mx, mag_mn, amp;
  logic [EW-1:0]           amp_e;
  logic                    sat_amp;
  logic [SR_W-1:0]         amp_word;
  logic [SR_W-1:0]         word;
  logic                    sat_evt;
  logic                    win_start;

  // Returns {saturated, value} for (v >>> SHIFT) clamped to signed OUT_W bits.
  function automatic logic [OUT_W:0] sat_iq(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if (s > IQ_MAX)      return {1'b1, IQ_MAX[OUT_W-1:0]};
    else if (s < IQ_MIN) return {1'b1, IQ_MIN[OUT_W-1:0]};
    else                 return {1'b0, s[OUT_W-1:0]};
  endfunction

  // |v| fits in ACC_W unsigned bits, including the most negative value.
  function automatic logic [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? -v : v;
  endfunction

  always_comb begin
    win_start = (cnt_q == '0);

    // reference bits selected by the shadowed subcarrier
    b_idx     = 3'd2 + {1'b0, sc_sh_q};
    cnt_sh_b  = cnt_q >> b_idx;
    cnt_sh_b1 = cnt_q >> (b_idx - 3'd1);
    ref_i     = ~cnt_sh_b[0];
    ref_q     = (cnt_sh_b[0] == cnt_sh_b1[0]);

    adc_ext = signed'({{(ACC_W-ADC_W){1'b0}}, adc_d});

    // formatting of the completed window
    iq_i     = sat_iq(acc_i_q);
    iq_q     = sat_iq(acc_q_q);
    mag_i    = mag(acc_i_q);
    mag_q    = mag(acc_q_q);
    mag_mx   = (mag_i > mag_q) ? mag_i : mag_q;
    mag_mn   = (mag_i > mag_q) ? mag_q : mag_i;
    amp      = mag_mx + (mag_mn >> 1);
    amp_e    = EW'(amp);
    sat_amp  = (amp_e > AMP_MAX);
    amp_word = sat_amp ? '1 : amp_e[SR_W-1:0];

    if (mode_sh_q[0] == 1'b0) begin
      word    = {iq_i[OUT_W-1:0], iq_q[OUT_W-1:0]};
      sat_evt = iq_i[OUT_W] | iq_q[OUT_W];
      if (mode_sh_q[1]) begin
        word[OUT_W] = h0_q;
        word[0]     = h1_q;
      end
    end else begin
      word    = amp_word;
      sat_evt = sat_amp;
      if (mode_sh_q[1]) word[1:0] = {h0_q, h1_q};
    end

    // defaults
    cnt_d     = cnt_q + CNT_ONE;
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    sr_d      = sr_q;
    mode_sh_d = mode_sh_q;
    sc_sh_d   = sc_sh_q;
    det_d     = det_q;
    hcnt_d    = hcnt_q;
    h0_d      = h0_q;
    h1_d      = h1_q;
    sat_d     = sat_q;
    clk_d     = clk_q;
    frame_d   = frame_q;
    valid_d   = win_start;

    if (win_start) begin
      acc_i_d   = adc_ext;
      acc_q_d   = adc_ext;
      sr_d      = word;
      mode_sh_d = mode;
      sc_sh_d   = sc_sel;
      h0_d      = det_q;
    end else begin
      acc_i_d = ref_i ? acc_i_q + adc_ext : acc_i_q - adc_ext;
      acc_q_d = ref_q ? acc_q_q + adc_ext : acc_q_q - adc_ext;
      if (cnt_q[1:0] == 2'd0) sr_d = {sr_q[SR_W-2:0], 1'b0};
    end

    if (cnt_q == CNT_HALF) h1_d = det_q;

    if (clr_sat)              sat_d = 1'b0;
    if (win_start && sat_evt) sat_d = 1'b1;

    if (cnt_q[1:0] == 2'd0)      clk_d = 1'b1;
    else if (cnt_q[1:0] == 2'd2) clk_d = 1'b0;

    if (cnt_q == CNT_ONE)        frame_d = 1'b1;
    else if (cnt_q == CNT_THREE) frame_d = 1'b0;

    // Reader-AM detector. The timeout overrides an all-zeros sample, so under a
    // constant zero input the detector pulses high for one cycle per timeout.
    if (&adc_d) begin
      det_d  = 1'b1;
      hcnt_d = '0;
    end else if (det_q) begin
      if (~|adc_d) det_d = 1'b0;
      hcnt_d = '0;
    end else if (hcnt_q == HC_LAST) begin
      det_d  = 1'b1;
      hcnt_d = '0;
    end else begin
      hcnt_d = hcnt_q + HC_W'(1);
    end
  end

  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      sr_q      <= '0;
      mode_sh_q <= '0;
      sc_sh_q   <= '0;
      det_q     <= 1'b0;
      hcnt_q    <= '0;
      h0_q      <= 1'b0;
      h1_q      <= 1'b0;
      sat_q     <= 1'b0;
      clk_q     <= 1'b0;
      frame_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      sr_q      <= sr_d;
      mode_sh_q <= mode_sh_d;
      sc_sh_q   <= sc_sh_d;
      det_q     <= det_d;
      hcnt_q    <= hcnt_d;
      h0_q      <= h0_d;
      h1_q      <= h1_d;
      sat_q     <= sat_d;
      clk_q     <= clk_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
    end
  end

  assign ssp_clk    = clk_q;
  assign ssp_frame  = frame_q;
  assign ssp_din    = sr_q[SR_W-1];
  assign corr_valid = valid_q;
  assign sat_flag   = sat_q;
  assign debug      = cnt_sh_b[0];

endmodule
